// File: rtl/pkt_hdr_extract_pkg.sv
// -----------------------------------------------------------------------------
// pkt_hdr_extract_pkg
//   Shared types and constants for the header-extract stage and its consumers.
//   metadata_t is the parser's in_meta record. This stage fills only pktID,
//   flits, empty and last_7_bytes. All remaining fields are left at zero for
//   later stages to fill.
// -----------------------------------------------------------------------------
package pkt_hdr_extract_pkg;

  localparam int DATA_W      = 512;                 // one 64-byte flit
  localparam int EMPTY_W     = 6;                   // invalid bytes in an eop flit
  localparam int DEF_PKT_NUM = 1024;                // default number of packet IDs
  localparam int PKT_AWIDTH  = $clog2(DEF_PKT_NUM); // width of metadata pktID
  localparam int META_FLIT_W = 16;                  // width of metadata flit count
  localparam int LAST_BYTES  = 7;                   // trailing bytes kept per packet
  localparam int TAIL_W      = LAST_BYTES * 8;

  typedef struct packed {
    logic [PKT_AWIDTH-1:0]  pktID;
    logic [META_FLIT_W-1:0] flits;
    logic [EMPTY_W-1:0]     empty;
    logic [TAIL_W-1:0]      last_7_bytes;
    logic [15:0]            pkt_len;
    logic [7:0]             prot;
    logic [31:0]            hash;
  } metadata_t;

endpackage

// File: rtl/pkt_hdr_extract_if.sv
// -----------------------------------------------------------------------------
// pkt_hdr_extract_if
//   Valid/ready packet flit stream, used on the RX input, the packet-buffer
//   output and the parser header output.
//   data  : flit, byte 0 at [511:504]
//   valid : flit present        ready : sink can take it
//   sop   : first flit          eop   : last flit
//   empty : invalid bytes at the tail of an eop flit
//   master drives data/valid/sop/eop/empty; slave drives ready.
// -----------------------------------------------------------------------------
interface pkt_hdr_extract_if;
  import pkt_hdr_extract_pkg::*;

  logic [DATA_W-1:0]  data;
  logic               valid;
  logic               ready;
  logic               sop;
  logic               eop;
  logic [EMPTY_W-1:0] empty;

  modport master (output data, valid, sop, eop, empty, input  ready);
  modport slave  (input  data, valid, sop, eop, empty, output ready);

endinterface

// File: rtl/pkt_hdr_extract_tail_bytes_sel.sv
// -----------------------------------------------------------------------------
// tail_bytes_sel
//   Picks the last 7 valid bytes of a packet from the eop flit. When fewer than
//   7 bytes of the eop flit are valid, the window extends into the tail of the
//   previous flit.
//   prev  : low 7 bytes of the previous flit (or zero)
//   data  : eop flit
//   empty : invalid bytes at the end of the eop flit
//   tail  : selected 7 bytes, oldest byte in the top bits
// -----------------------------------------------------------------------------
module tail_bytes_sel
  import pkt_hdr_extract_pkg::*;
(
  input  logic [TAIL_W-1:0]  prev,
  input  logic [DATA_W-1:0]  data,
  input  logic [EMPTY_W-1:0] empty,
  output logic [TAIL_W-1:0]  tail
);

  logic [TAIL_W+DATA_W-1:0] joined;
  logic [9:0]               bit_ofs;

  // Invalid bytes sit at the low end of the big-endian flit. Skipping
  // empty*8 bits from the bottom places the window on the last valid byte.
  assign joined  = {prev, data};
  assign bit_ofs = {1'b0, empty, 3'b000};
  assign tail    = joined[bit_ofs +: TAIL_W];

endmodule

// File: rtl/pkt_hdr_extract.sv
// -----------------------------------------------------------------------------
// pkt_hdr_extract
//   Placed between the Ethernet RX stream and the parser / packet buffer.
//   Every accepted flit is forwarded to the packet buffer through one register
//   stage, except stray flits that arrive outside a packet. The first flit of
//   each packet is captured. At eop it is emitted to the parser as a single
//   sop=eop=1 flit, together with partially filled metadata.
//
//   clk, rst        : clock, synchronous active-high reset
//   in_pkt          : RX flit stream (slave)
//   out_pkt         : forwarded stream to the packet buffer (master)
//   out_hdr         : first flit of each packet, to the parser (master)
//   out_meta_*      : metadata for the parser. Forms one slot with out_hdr.
//   stat_pkt_cnt    : packets emitted (wraps)
//   stat_err_cnt    : framing errors: stray flit, or sop inside a packet (wraps)
// -----------------------------------------------------------------------------
module pkt_hdr_extract
  import pkt_hdr_extract_pkg::*;
#(
  parameter int PKT_NUM = DEF_PKT_NUM,
  parameter int FLIT_W  = META_FLIT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  pkt_hdr_extract_if.slave         in_pkt,
  pkt_hdr_extract_if.master        out_pkt,
  pkt_hdr_extract_if.master        out_hdr,
  output metadata_t                out_meta_data,
  output logic                     out_meta_valid,
  input  logic                     out_meta_ready,
  output logic [31:0]              stat_pkt_cnt,
  output logic [31:0]              stat_err_cnt
);

  localparam int               PID_W    = (PKT_NUM > 1) ? $clog2(PKT_NUM) : 1;
  localparam logic [PID_W-1:0] PID_LAST = PID_W'(PKT_NUM - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BODY = 1'b1;

  logic [0:0]         state;
  logic [DATA_W-1:0]  hdr_q;
  logic [FLIT_W-1:0]  flit_cnt;
  logic [TAIL_W-1:0]  prev_tail;
  logic [PID_W-1:0]   pid_cnt;

  logic               fwd_valid_q;
  logic [DATA_W-1:0]  fwd_data_q;
  logic               fwd_sop_q;
  logic               fwd_eop_q;
  logic [EMPTY_W-1:0] fwd_empty_q;

  logic               slot_valid_q;
  logic [DATA_W-1:0]  slot_hdr_q;
  logic [EMPTY_W-1:0] slot_empty_q;
  metadata_t          slot_meta_q;

  logic               pkt_adv;
  logic               slot_free;
  logic               slot_consume;
  logic               accept;
  logic               in_body;
  logic               drop;
  logic               fwd;
  logic               emit;
  logic               framing_err;
  logic [FLIT_W-1:0]  flits_inc;
  logic [FLIT_W-1:0]  emit_flits;
  logic [DATA_W-1:0]  emit_hdr;
  logic [TAIL_W-1:0]  tail_prev;
  logic [TAIL_W-1:0]  emit_tail;
  metadata_t          emit_meta;

  // ---------------------------------------------------------------------------
  // Handshake. Ready comes only from output-side state, never from in_pkt.valid.
  // ---------------------------------------------------------------------------
  assign pkt_adv      = !fwd_valid_q || out_pkt.ready;
  assign slot_free    = !slot_valid_q || (out_meta_ready && out_hdr.ready);
  assign slot_consume = slot_valid_q && out_meta_ready && out_hdr.ready;
  assign in_pkt.ready = pkt_adv && slot_free;

  assign accept      = in_pkt.valid && in_pkt.ready;
  assign in_body     = (state == ST_BODY);
  assign drop        = accept && !in_pkt.sop && !in_body;
  assign fwd         = accept && !drop;
  assign emit        = accept && in_pkt.eop && (in_pkt.sop || in_body);
  assign framing_err = drop || (accept && in_pkt.sop && in_body);

  assign flits_inc  = (&flit_cnt) ? flit_cnt : flit_cnt + FLIT_W'(1);
  // A sop flit starts a fresh packet even if one was already open.
  assign emit_flits = in_pkt.sop ? FLIT_W'(1) : flits_inc;
  assign emit_hdr   = in_pkt.sop ? in_pkt.data : hdr_q;
  assign tail_prev  = in_pkt.sop ? '0 : prev_tail;

  tail_bytes_sel u_tail_bytes_sel (
    .prev  (tail_prev),
    .data  (in_pkt.data),
    .empty (in_pkt.empty),
    .tail  (emit_tail)
  );

  // NOTE: each combinational output gets a default before any assignment, so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    emit_meta              = '0;
    emit_meta.pktID        = PKT_AWIDTH'(pid_cnt);
    emit_meta.flits        = META_FLIT_W'(emit_flits);
    emit_meta.empty        = in_pkt.empty;
    emit_meta.last_7_bytes = emit_tail;
  end

  // ---------------------------------------------------------------------------
  // Forwarding register toward the packet buffer (latency 1)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_valid_q <= 1'b0;
      fwd_data_q  <= '0;
      fwd_sop_q   <= 1'b0;
      fwd_eop_q   <= 1'b0;
      fwd_empty_q <= '0;
    end else if (pkt_adv) begin
      fwd_valid_q <= fwd;
      if (fwd) begin
        fwd_data_q  <= in_pkt.data;
        fwd_sop_q   <= in_pkt.sop;
        fwd_eop_q   <= in_pkt.eop;
        fwd_empty_q <= in_pkt.empty;
      end
    end
  end

  assign out_pkt.valid = fwd_valid_q;
  assign out_pkt.data  = fwd_data_q;
  assign out_pkt.sop   = fwd_sop_q;
  assign out_pkt.eop   = fwd_eop_q;
  assign out_pkt.empty = fwd_empty_q;

  // ---------------------------------------------------------------------------
  // Packet tracking: header capture, flit count, previous-flit tail
  // ---------------------------------------------------------------------------
  // NOTE: the wide header register is reset along with the control state.
  // Its contents can reach out_hdr_data, and that output must read zero
  // after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      hdr_q     <= '0;
      flit_cnt  <= '0;
      prev_tail <= '0;
    end else if (accept) begin
      if (in_pkt.sop) begin
        hdr_q     <= in_pkt.data;
        flit_cnt  <= FLIT_W'(1);
        prev_tail <= '0;
        state     <= in_pkt.eop ? ST_IDLE : ST_BODY;
      end else if (in_body) begin
        flit_cnt  <= flits_inc;
        prev_tail <= in_pkt.data[TAIL_W-1:0];
        if (in_pkt.eop) state <= ST_IDLE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Header/metadata slot. A new emit wins over a same-cycle consume, so the
  // slot reloads and stays valid.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid_q <= 1'b0;
      slot_hdr_q   <= '0;
      slot_empty_q <= '0;
      slot_meta_q  <= '0;
    end else if (emit) begin
      slot_valid_q <= 1'b1;
      slot_hdr_q   <= emit_hdr;
      slot_empty_q <= in_pkt.sop ? in_pkt.empty : '0;
      slot_meta_q  <= emit_meta;
    end else if (slot_consume) begin
      slot_valid_q <= 1'b0;
    end
  end

  assign out_hdr.valid  = slot_valid_q;
  assign out_hdr.data   = slot_hdr_q;
  assign out_hdr.sop    = slot_valid_q;
  assign out_hdr.eop    = slot_valid_q;
  assign out_hdr.empty  = slot_empty_q;
  assign out_meta_valid = slot_valid_q;
  assign out_meta_data  = slot_meta_q;

  // ---------------------------------------------------------------------------
  // Packet ID and statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pid_cnt      <= '0;
      stat_pkt_cnt <= '0;
      stat_err_cnt <= '0;
    end else begin
      if (emit) begin
        pid_cnt      <= (pid_cnt == PID_LAST) ? '0 : pid_cnt + PID_W'(1);
        stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
      end
      if (framing_err) stat_err_cnt <= stat_err_cnt + 32'd1;
    end
  end

endmodule
